obi_mem_responder: RTL and testbench

//  OBI slave-side memory model/responder: the far end of instr_mem / data_mem OBI master

---
 rtl/obi_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_obi_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// -----------------------------------------------------------------------------
// obi_mem_responder
//
// Slave side of an OBI port, backed by an internal word-organised SRAM.
// Requests are granted after a programmable number of wait cycles. An accepted
// transfer either writes the enabled byte lanes or reads a whole word. Every
// accepted transfer returns exactly one response, a fixed RSP_LATENCY cycles
// after the transfer edge. Responses come back in request order.
//
// Parameters
//   MEM_SIZE_BYTE  memory size in bytes (power of two, >= 8)
//   GNT_WAIT       cycles req_i must be held before gnt_o rises (0 = same cycle)
//   RSP_LATENCY    cycles from the transfer edge to rvalid_o (1..8)
//
// Ports
//   clk_i     clock; all state changes on the rising edge
//   rst_i     asynchronous reset, active high
//   req_i     request valid
//   gnt_o     grant; a transfer happens in a cycle with req_i && gnt_o
//   addr_i    byte address; bits [1:0] are ignored for decode
//   we_i      1 = write, 0 = read
//   be_i      byte enables; bit n qualifies wdata_i[8n+7:8n]
//   wdata_i   write data
//   rvalid_o  one-cycle response pulse per granted request
//   rdata_o   read data; 0 for write and error responses and when idle
//   err_o     response error (address out of range); qualified by rvalid_o
// -----------------------------------------------------------------------------
module obi_mem_responder #(
    parameter int unsigned MEM_SIZE_BYTE = 32768,
    parameter int unsigned GNT_WAIT      = 0,
    parameter int unsigned RSP_LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW    = $clog2(MEM_SIZE_BYTE);
    localparam int unsigned DEPTH = MEM_SIZE_BYTE / 4;
    localparam int unsigned CW    = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_GRANT = CW'(GNT_WAIT);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_gnt;
    logic          w_xfer;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. With GNT_WAIT == 0 the FSM never leaves IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (GNT_WAIT != 0) begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!req_i) begin
                        // Master withdrew the request before the grant.
                        // Abandon it silently.
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_GRANT) begin
                        // Grant is high and req_i is held: the transfer
                        // completes this cycle.
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Output logic. The grant is forced low while reset is asserted so the
    // master cannot observe a grant during reset.
    always_comb begin
        w_gnt = 1'b0;
        if (GNT_WAIT == 0) begin
            w_gnt = req_i;
        end else begin
            w_gnt = (r_state == S_WAIT) && (r_cnt == CNT_GRANT);
        end
        gnt_o = w_gnt & ~rst_i;
    end

    assign w_xfer = req_i & gnt_o;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          w_oor;
    logic [AW-3:0] w_idx;

    assign w_oor = (addr_i >= 32'(MEM_SIZE_BYTE));
    assign w_idx = addr_i[AW-1:2];

    // ------------------------------------------------------------------
    // Memory: one byte-wide array per lane. Each lane has a registered read
    // port so the arrays map directly onto block RAM with byte enables.
    // The contents are not reset.
    // ------------------------------------------------------------------
    logic [31:0] w_mem_rdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_lane_mem [DEPTH];
        logic [7:0] r_lane_rdata;

        always_ff @(posedge clk_i) begin
            if (w_xfer && !w_oor) begin
                if (we_i) begin
                    if (be_i[gi]) begin
                        r_lane_mem[w_idx] <= wdata_i[8*gi +: 8];
                    end
                end else begin
                    r_lane_rdata <= r_lane_mem[w_idx];
                end
            end
        end

        assign w_mem_rdata[8*gi +: 8] = r_lane_rdata;
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // Stage 0 is loaded at the transfer edge. Its data comes straight from
    // the lane read registers. Those registers cannot be reset, so their
    // output is masked with a reset-cleared read flag. Later stages carry the
    // already-masked word, which keeps rdata_o at zero outside valid read
    // responses.
    // ------------------------------------------------------------------
    logic [RSP_LATENCY-1:0] r_vld;
    logic [RSP_LATENCY-1:0] r_err;
    logic                   r_rd0;
    logic [31:0]            w_data0;
    logic [31:0]            w_rdata_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_err <= '0;
            r_rd0 <= 1'b0;
        end else begin
            r_vld[0] <= w_xfer;
            r_err[0] <= w_xfer & w_oor;
            r_rd0    <= w_xfer & ~we_i & ~w_oor;
            for (int i = 1; i < int'(RSP_LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    assign w_data0 = r_rd0 ? w_mem_rdata : 32'h0;

    if (RSP_LATENCY > 1) begin : g_dpipe
        logic [RSP_LATENCY-2:0][31:0] r_dpipe;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_dpipe <= '0;
            end else begin
                r_dpipe[0] <= w_data0;
                for (int i = 1; i < int'(RSP_LATENCY) - 1; i++) begin
                    r_dpipe[i] <= r_dpipe[i-1];
                end
            end
        end

        assign w_rdata_last = r_dpipe[RSP_LATENCY-2];
    end else begin : g_nopipe
        assign w_rdata_last = w_data0;
    end

    assign rvalid_o = r_vld[RSP_LATENCY-1];
    assign err_o    = r_err[RSP_LATENCY-1];
    assign rdata_o  = w_rdata_last;

endmodule

// File: tb/tb_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_obi_mem_responder
//
// Directed testbench for obi_mem_responder. It uses three instances:
//   dut0  GNT_WAIT=0, RSP_LATENCY=1  reset, read/write, partial write,
//                                    read-after-write, out-of-range accesses
//   dut1  GNT_WAIT=3, RSP_LATENCY=1  grant wait states and abandoned request
//   dut2  GNT_WAIT=0, RSP_LATENCY=3  pipelined responses, reset mid-pipeline
// -----------------------------------------------------------------------------
module tb_obi_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0, gnt0, we0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;
    logic        req1, gnt1, we1, rvalid1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;
    logic        req2, gnt2, we2, rvalid2, err2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  be2;

    obi_mem_responder #(.MEM_SIZE_BYTE(32768), .GNT_WAIT(0), .RSP_LATENCY(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .addr_i(addr0),
        .we_i(we0), .be_i(be0), .wdata_i(wdata0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0)
    );

    obi_mem_responder #(.MEM_SIZE_BYTE(32768), .GNT_WAIT(3), .RSP_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .addr_i(addr1),
        .we_i(we1), .be_i(be1), .wdata_i(wdata1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1)
    );

    obi_mem_responder #(.MEM_SIZE_BYTE(32768), .GNT_WAIT(0), .RSP_LATENCY(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2),
        .we_i(we2), .be_i(be2), .wdata_i(wdata2), .rvalid_o(rvalid2),
        .rdata_o(rdata2), .err_o(err2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle transfer on dut0. On return, the response (latency 1) is visible.
    task automatic op0(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        req0   = 1'b1;
        we0    = w;
        addr0  = a;
        be0    = b;
        wdata0 = d;
        tick();
        req0 = 1'b0;
        we0  = 1'b0;
        $display("dut0 %s addr=%h be=%h wdata=%h -> rvalid=%0d rdata=%h err=%0d",
                 w ? "WR" : "RD", a, b, d, rvalid0, rdata0, err0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = '0; wdata2 = '0;

        // ---------------- reset ----------------
        req0 = 1'b1;
        tick();
        tick();
        chk_val("rst_gnt0",   32'(gnt0),    32'h0);
        chk_val("rst_rvalid0", 32'(rvalid0), 32'h0);
        chk_val("rst_rdata0",  rdata0,       32'h0);
        chk_val("rst_err0",    32'(err0),    32'h0);
        rst = 1'b0;
        #1;
        chk_val("gnt0_follow_req1", 32'(gnt0), 32'h1);
        req0 = 1'b0;
        #1;
        chk_val("gnt0_follow_req0", 32'(gnt0), 32'h0);
        tick();
        $display("reset released, gnt0 follows req0");

        // ---------------- full write / read ----------------
        op0(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        chk_val("wr_rvalid", 32'(rvalid0), 32'h1);
        chk_val("wr_rdata",  rdata0,       32'h0);
        chk_val("wr_err",    32'(err0),    32'h0);
        op0(1'b0, 32'h100, 4'h0, 32'h0);
        chk_val("rd_rvalid", 32'(rvalid0), 32'h1);
        chk_val("rd_rdata",  rdata0,       32'hDEADBEEF);
        chk_val("rd_err",    32'(err0),    32'h0);
        tick();
        chk_val("idle_rvalid", 32'(rvalid0), 32'h0);
        chk_val("idle_rdata",  rdata0,       32'h0);

        // ---------------- partial write ----------------
        op0(1'b1, 32'h100, 4'b0010, 32'h0000AA00);
        op0(1'b0, 32'h100, 4'h0, 32'h0);
        chk_val("pw_rdata", rdata0, 32'hDEADAAEF);

        // ---------------- be=0 write ----------------
        op0(1'b1, 32'h100, 4'h0, 32'hFFFFFFFF);
        chk_val("be0_rvalid", 32'(rvalid0), 32'h1);
        chk_val("be0_err",    32'(err0),    32'h0);
        op0(1'b0, 32'h100, 4'h0, 32'h0);
        chk_val("be0_rdata", rdata0, 32'hDEADAAEF);

        // ---------------- back-to-back read after write ----------------
        op0(1'b1, 32'h200, 4'hF, 32'h12345678);
        chk_val("raw_wr_rdata", rdata0, 32'h0);
        op0(1'b0, 32'h200, 4'h0, 32'h0);
        chk_val("raw_rd_rdata", rdata0, 32'h12345678);

        // ---------------- address boundaries ----------------
        op0(1'b1, 32'h7FFC, 4'hF, 32'hA5A5A5A5);
        op0(1'b0, 32'h7FFC, 4'h0, 32'h0);
        chk_val("top_rdata", rdata0, 32'hA5A5A5A5);
        chk_val("top_err",   32'(err0), 32'h0);
        op0(1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        op0(1'b0, 32'h8000, 4'h0, 32'h0);
        chk_val("oor_rd_rvalid", 32'(rvalid0), 32'h1);
        chk_val("oor_rd_err",    32'(err0),    32'h1);
        chk_val("oor_rd_rdata",  rdata0,       32'h0);
        op0(1'b1, 32'h8000, 4'hF, 32'h11111111);
        chk_val("oor_wr_err", 32'(err0), 32'h1);
        op0(1'b0, 32'h0, 4'h0, 32'h0);
        chk_val("oor_mem_kept", rdata0,    32'hCAFEF00D);
        chk_val("oor_after_err", 32'(err0), 32'h0);

        // ---------------- grant wait states (dut1) ----------------
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; be1 = 4'hF; wdata1 = 32'h55AA55AA;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk_val($sformatf("gw_wr_gnt_c%0d", c), 32'(gnt1), (c == 4) ? 32'h1 : 32'h0);
            $display("dut1 wr cycle %0d gnt=%0d", c, gnt1);
            @(posedge clk);
            #1;
        end
        req1 = 1'b0; we1 = 1'b0;
        chk_val("gw_wr_rvalid", 32'(rvalid1), 32'h1);
        chk_val("gw_wr_err",    32'(err1),    32'h0);

        // Request withdrawn after two cycles: no grant and no response.
        req1 = 1'b1; addr1 = 32'h10;
        for (int c = 1; c <= 2; c++) begin
            #1;
            chk_val($sformatf("drop_gnt_c%0d", c), 32'(gnt1), 32'h0);
            @(posedge clk);
            #1;
        end
        req1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk_val($sformatf("drop_idle_gnt_c%0d", c), 32'(gnt1), 32'h0);
            chk_val($sformatf("drop_rvalid_c%0d", c), 32'(rvalid1), 32'h0);
            tick();
        end
        $display("dut1 withdrawn request produced no grant/response");

        // The next request waits again. The address changes before the grant
        // and must be ignored.
        req1 = 1'b1; we1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            addr1 = (c < 4) ? 32'h20 : 32'h10;
            #1;
            chk_val($sformatf("gw_rd_gnt_c%0d", c), 32'(gnt1), (c == 4) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
        end
        req1 = 1'b0;
        chk_val("gw_rd_rvalid", 32'(rvalid1), 32'h1);
        chk_val("gw_rd_rdata",  rdata1,       32'h55AA55AA);
        $display("dut1 rd addr=10 -> rvalid=%0d rdata=%h", rvalid1, rdata1);

        // ---------------- pipelined responses (dut2, latency 3) ----------------
        for (int i = 0; i < 4; i++) begin
            req2 = 1'b1; we2 = 1'b1; addr2 = 32'(4 * i); be2 = 4'hF;
            wdata2 = 32'h0BAD0000 + 32'(i);
            tick();
        end
        req2 = 1'b0; we2 = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                req2 = 1'b1; addr2 = 32'(4 * k);
            end else begin
                req2 = 1'b0;
            end
            tick();
            chk_val($sformatf("pipe_rvalid_k%0d", k), 32'(rvalid2),
                    (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
            if (k >= 2 && k <= 5) begin
                chk_val($sformatf("pipe_rdata_k%0d", k), rdata2, 32'h0BAD0000 + 32'(k - 2));
                chk_val($sformatf("pipe_err_k%0d", k), 32'(err2), 32'h0);
            end
            $display("dut2 cycle %0d rvalid=%0d rdata=%h", k, rvalid2, rdata2);
        end

        // ---------------- reset with responses in flight ----------------
        req2 = 1'b1; addr2 = 32'h4;
        tick();
        addr2 = 32'h8;
        tick();
        req2 = 1'b0;
        rst = 1'b1;
        #1;
        chk_val("inflight_rst_rvalid", 32'(rvalid2), 32'h0);
        chk_val("inflight_rst_rdata",  rdata2,       32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_val($sformatf("post_rst_rvalid_c%0d", c), 32'(rvalid2), 32'h0);
        end
        $display("dut2 in-flight responses dropped by reset");

        // Memory contents survive reset.
        req2 = 1'b1; addr2 = 32'h4;
        tick();
        req2 = 1'b0;
        tick();
        tick();
        chk_val("post_rst_rd_rvalid", 32'(rvalid2), 32'h1);
        chk_val("post_rst_rd_rdata",  rdata2,       32'h0BAD0001);
        $display("dut2 rd addr=4 after reset -> rvalid=%0d rdata=%h", rvalid2, rdata2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
